// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: default widths and MIPS R-type function codes.
package alu_pkg;

  localparam int unsigned NB_OP_DEF   = 6;
  localparam int unsigned NB_DATA_DEF = 8;

  localparam logic [5:0] ADD_OP = 6'b100000;
  localparam logic [5:0] SUB_OP = 6'b100010;
  localparam logic [5:0] AND_OP = 6'b100100;
  localparam logic [5:0] OR_OP  = 6'b100101;
  localparam logic [5:0] XOR_OP = 6'b100110;
  localparam logic [5:0] NOR_OP = 6'b100111;
  localparam logic [5:0] SRL_OP = 6'b000010;
  localparam logic [5:0] SRA_OP = 6'b000011;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the ALU: result and signed-overflow flag from op, A and B.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned NB_OP   = NB_OP_DEF,
  parameter int unsigned NB_DATA = NB_DATA_DEF
) (
  input  logic [NB_OP-1:0]   op,
  input  logic [NB_DATA-1:0] data_a,
  input  logic [NB_DATA-1:0] data_b,
  output logic [NB_DATA-1:0] result_c,
  output logic               overflow_c
);

  localparam int unsigned MSB = NB_DATA - 1;

  logic [NB_DATA-1:0] sum;
  logic [NB_DATA-1:0] diff;

  assign sum  = data_a + data_b;
  assign diff = data_a - data_b;

  always_comb begin
    result_c   = '0;
    overflow_c = 1'b0;
    case (op)
      NB_OP'(ADD_OP): begin
        result_c   = sum;
        overflow_c = (data_a[MSB] == data_b[MSB]) && (sum[MSB] != data_a[MSB]);
      end
      NB_OP'(SUB_OP): begin
        result_c   = diff;
        overflow_c = (data_a[MSB] != data_b[MSB]) && (diff[MSB] != data_a[MSB]);
      end
      NB_OP'(AND_OP): result_c = data_a & data_b;
      NB_OP'(OR_OP):  result_c = data_a | data_b;
      NB_OP'(XOR_OP): result_c = data_a ^ data_b;
      NB_OP'(NOR_OP): result_c = ~(data_a | data_b);
      // B is an unsigned amount; amounts >= NB_DATA saturate to zero / sign fill.
      NB_OP'(SRL_OP): result_c = data_a >> data_b;
      NB_OP'(SRA_OP): result_c = NB_DATA'($signed(data_a) >>> data_b);
      default: begin
        result_c   = '0;
        overflow_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: registers the core result, flags and valid strobe once per clock.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned NB_OP   = NB_OP_DEF,
  parameter int unsigned NB_DATA = NB_DATA_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_A,
  input  logic [NB_DATA-1:0] i_data_B,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_zero,
  output logic               o_overflow
);

  logic [NB_DATA-1:0] result_c;
  logic               overflow_c;

  alu_core #(
    .NB_OP   (NB_OP),
    .NB_DATA (NB_DATA)
  ) u_core (
    .op         (i_op),
    .data_a     (i_data_A),
    .data_b     (i_data_B),
    .result_c   (result_c),
    .overflow_c (overflow_c)
  );

  // Result and flags load only on valid cycles; o_valid is a one-cycle strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_zero     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data     <= result_c;
        o_zero     <= (result_c == '0);
        o_overflow <= overflow_c;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model plus directed literal vectors.
module tb_alu;

  localparam int unsigned NB_OP   = 6;
  localparam int unsigned NB_DATA = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid = 1'b0;
  logic [5:0]       i_op = '0;
  logic [7:0]       i_data_a = '0;
  logic [7:0]       i_data_b = '0;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             o_zero;
  logic             o_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_zero = 1'b0;
  logic       m_ovf = 1'b0;

  alu #(.NB_OP(NB_OP), .NB_DATA(NB_DATA)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .i_op       (i_op),
    .i_data_A   (i_data_a),
    .i_data_B   (i_data_b),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_zero     (o_zero),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%02h, expected 0x%02h", nm, $time, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the signed/unsigned values of A and B.
  task automatic model_op(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic ov);
    int sa, sb, ua, ub, s, k, d, q;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    r  = '0;
    ov = 1'b0;
    case (op)
      6'b100000: begin s = sa + sb; ov = (s > 127) || (s < -128); r = s[7:0]; end
      6'b100010: begin s = sa - sb; ov = (s > 127) || (s < -128); r = s[7:0]; end
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b000010: begin
        if (ub >= 8) r = 8'h00;
        else begin q = ua / (1 << ub); r = q[7:0]; end
      end
      6'b000011: begin
        k = (ub >= 8) ? 8 : ub;
        d = 1 << k;
        q = sa / d;
        if ((sa < 0) && ((sa % d) != 0)) q = q - 1;
        r = q[7:0];
      end
      default: begin r = 8'h00; ov = 1'b0; end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data = '0; m_valid = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else begin
      m_valid = i_valid;
      if (i_valid) begin
        model_op(i_op, i_data_a, i_data_b, m_data, m_ovf);
        m_zero = (m_data == 8'h00);
      end
    end
  end

  // Outputs are always meaningful (held when idle), so compare every cycle.
  always @(negedge clk) begin
    check("cyc_valid", {7'b0, o_valid}, {7'b0, m_valid});
    check("cyc_data", o_data, m_data);
    check("cyc_zero", {7'b0, o_zero}, {7'b0, m_zero});
    check("cyc_ovf", {7'b0, o_overflow}, {7'b0, m_ovf});
  end

  task automatic do_op(input string nm, input logic [5:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input logic ov,
                       input logic z);
    @(negedge clk); #1;
    i_valid = 1'b1; i_op = op; i_data_a = a; i_data_b = b;
    @(posedge clk); #2;
    check({nm, "_valid"}, {7'b0, o_valid}, 8'h01);
    check({nm, "_data"}, o_data, exp);
    check({nm, "_ovf"}, {7'b0, o_overflow}, {7'b0, ov});
    check({nm, "_zero"}, {7'b0, o_zero}, {7'b0, z});
    check({nm, "_model"}, m_data, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #2;
    check("rst_valid", {7'b0, o_valid}, 8'h00);
    check("rst_data", o_data, 8'h00);

    // Reset mid-stream while holding a valid 0x0F result.
    do_op("add_10_5", 6'b100000, 8'd10, 8'd5, 8'h0F, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {7'b0, o_valid}, 8'h00);
    check("arst_data", o_data, 8'h00);
    check("arst_zero", {7'b0, o_zero}, 8'h00);
    check("arst_ovf", {7'b0, o_overflow}, 8'h00);
    @(negedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    @(posedge clk); #2;
    check("post_rst_valid", {7'b0, o_valid}, 8'h00);
    check("post_rst_data", o_data, 8'h00);

    do_op("add_10_5b", 6'b100000, 8'd10, 8'd5, 8'd15, 1'b0, 1'b0);
    do_op("sub_15_5", 6'b100010, 8'd15, 8'd5, 8'd10, 1'b0, 1'b0);
    do_op("add_ovf", 6'b100000, 8'd127, 8'd1, 8'h80, 1'b1, 1'b0);
    do_op("sub_zero", 6'b100010, 8'd5, 8'd5, 8'h00, 1'b0, 1'b1);
    do_op("sub_ovf", 6'b100010, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
    do_op("and", 6'b100100, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0);
    do_op("or", 6'b100101, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0);
    do_op("xor", 6'b100110, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0);
    do_op("nor", 6'b100111, 8'hCC, 8'hAA, 8'h11, 1'b0, 1'b0);
    do_op("sra_neg", 6'b000011, 8'hF0, 8'd2, 8'hFC, 1'b0, 1'b0);
    do_op("srl_16", 6'b000010, 8'd16, 8'd2, 8'h04, 1'b0, 1'b0);
    do_op("srl_f0", 6'b000010, 8'hF0, 8'd2, 8'h3C, 1'b0, 1'b0);
    do_op("sra_big", 6'b000011, 8'h80, 8'd9, 8'hFF, 1'b0, 1'b0);
    do_op("srl_big", 6'b000010, 8'h80, 8'd9, 8'h00, 1'b0, 1'b1);
    do_op("undef", 6'b111111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1);
    do_op("add_3_4", 6'b100000, 8'd3, 8'd4, 8'h07, 1'b0, 1'b0);

    @(negedge clk); #1 i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("idle_valid", {7'b0, o_valid}, 8'h00);
      check("idle_hold", o_data, 8'h07);
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
